// File: rtl/uart_rx_deser.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_deser
// Brief  : 8N1 UART receiver with valid/ready byte output and sticky error
//          flags. Optional even-parity check via `UART_RX_PARITY_EN.
// Rev    : 1.0
// ============================================================================
module uart_rx_deser #(
    parameter int PRESC_W   = 16,
    parameter int MIN_PRESC = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [PRESC_W-1:0] baud_prescaler,
    input  logic               rx,
    output logic [7:0]         data_o,
    output logic               valid,
    input  logic               ready,
    output logic               frame_error,
    output logic               overrun,
`ifdef UART_RX_PARITY_EN
    output logic               parity_error,
`endif
    input  logic               clear_flags
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif
    localparam logic [PRESC_W-1:0] c_one       = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] c_min_presc = PRESC_W'(MIN_PRESC);

    logic               rx_meta_q, rx_s_q;
    logic [2:0]         state_q, state_d;
    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic [PRESC_W-1:0] p_q, p_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               armed_q, armed_d;
    logic               deliver_q, deliver_d;
    logic [7:0]         data_q;
    logic               valid_q, ferr_q, ovr_q;

    logic [PRESC_W-1:0] w_p_eff, w_half_last;
    logic               w_bit_end, w_ferr_set, w_ovr_set;
`ifdef UART_RX_PARITY_EN
    logic               par_q, par_d, perr_q, w_perr_set, w_par_bad;
    assign w_par_bad    = ^{shreg_q, par_q};
    assign parity_error = perr_q;
`endif

    assign w_p_eff     = (baud_prescaler < c_min_presc) ? c_min_presc : baud_prescaler;
    assign w_half_last = (p_q >> 1) - c_one;
    assign w_bit_end   = (cnt_q == (p_q - c_one));
    // A delivery against an unconsumed byte drops the new byte.
    assign w_ovr_set   = deliver_q & valid_q & ~ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        armed_d    = armed_q;
        deliver_d  = 1'b0;
        w_ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        w_perr_set = 1'b0;
`endif
        if (!enable) begin
            state_d = S_IDLE;
            if (rx_s_q) armed_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rx_s_q) armed_d = 1'b1;
                    if (armed_q && !rx_s_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                        p_d     = w_p_eff;
                    end
                end
                S_START: begin
                    if (cnt_q == w_half_last) begin
                        cnt_d   = '0;
                        idx_d   = 3'd0;
                        state_d = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + c_one;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        cnt_d   = '0;
                        shreg_d = {rx_s_q, shreg_q[7:1]};
                        idx_d   = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (idx_q == 3'd7) state_d = S_PARITY;
`else
                        if (idx_q == 3'd7) state_d = S_STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + c_one;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        cnt_d   = '0;
                        par_d   = rx_s_q;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + c_one;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                        // A low stop disarms so a held break cannot retrigger.
                        if (!rx_s_q) begin
                            w_ferr_set = 1'b1;
                            armed_d    = 1'b0;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (w_par_bad) w_perr_set = 1'b1;
`endif
                        else deliver_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + c_one;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            p_q       <= c_min_presc;
            idx_q     <= 3'd0;
            shreg_q   <= 8'h00;
            armed_q   <= 1'b1;
            deliver_q <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            armed_q   <= armed_d;
            deliver_q <= deliver_d;
            if (deliver_q) begin
                if (!valid_q || ready) begin
                    data_q  <= shreg_q;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
            ferr_q <= w_ferr_set | (ferr_q & ~clear_flags);
            ovr_q  <= w_ovr_set  | (ovr_q  & ~clear_flags);
`ifdef UART_RX_PARITY_EN
            par_q  <= par_d;
            perr_q <= w_perr_set | (perr_q & ~clear_flags);
`endif
        end
    end

    assign data_o      = data_q;
    assign valid       = valid_q;
    assign frame_error = ferr_q;
    assign overrun     = ovr_q;

endmodule
`default_nettype wire
